// File: rtl/fft_pkg.sv
// Shared defaults, address types and controller state encoding for the FFT
// stage sequencer.
package fft_pkg;

    localparam int DEF_N      = 64;
    localparam int DEF_LOGN   = $clog2(DEF_N);
    localparam int DEF_BF_LAT = 3;

    typedef logic [DEF_LOGN-1:0] addr_t;
    typedef logic [DEF_LOGN-2:0] tw_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/fft_addr_fifo.sv
// Small circular FIFO carrying (u,b) write-back address pairs from read
// issue to butterfly result.
module fft_addr_fifo
    import fft_pkg::*;
#(
    parameter int W     = 2 * DEF_LOGN,
    parameter int DEPTH = DEF_BF_LAT + 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_empty,
    output logic         o_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 1);

    logic [W-1:0]    r_mem [DEPTH];
    logic [PW-1:0]   r_wp;
    logic [PW-1:0]   r_rp;
    logic [CNTW-1:0] r_cnt;
    logic            w_push;
    logic            w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CNTW'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_dout  = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= (r_wp == P_LAST) ? '0 : r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= (r_rp == P_LAST) ? '0 : r_rp + 1'b1;
            end
            r_cnt <= r_cnt + CNTW'(w_push) - CNTW'(w_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && o_full && !i_pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_pop && o_empty));
    a_empty_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(o_empty && o_full));

endmodule

// File: rtl/fft_stage_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT.
// Optional FFT_STAGE_CTRL_CYCCNT_EN adds a cycle_count output.
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int LOGN   = $clog2(N),
    parameter int BF_LAT = DEF_BF_LAT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            mem_rd_en,
    output logic [LOGN-1:0] mem_rd_addr_u,
    output logic [LOGN-1:0] mem_rd_addr_b,
    output logic [LOGN-2:0] tw_addr,
    output logic            bf_en,
    input  logic            bf_valid,
    output logic            mem_wr_en,
    output logic [LOGN-1:0] mem_wr_addr_u,
    output logic [LOGN-1:0] mem_wr_addr_b
`ifdef FFT_STAGE_CTRL_CYCCNT_EN
    ,
    output logic [31:0]     cycle_count
`endif
);

    localparam int CW = $clog2(BF_LAT + 3);
    localparam int AW = 2 * LOGN;
    localparam logic [LOGN-2:0] J_LAST = (LOGN-1)'(N / 2 - 1);
    localparam logic [LOGN-1:0] S_LAST = LOGN'(LOGN - 1);

    state_e          r_state;
    logic [LOGN-1:0] r_s;
    logic [LOGN-2:0] r_j;
    logic [CW-1:0]   r_cnt;
    logic            r_bf_en;
    logic            r_err;

    logic            w_rd_en;
    logic            w_start_ok;
    logic            w_dec;
    logic [LOGN-1:0] w_half;
    logic [LOGN-1:0] w_mask;
    logic [LOGN-1:0] w_jx;
    logic [LOGN-1:0] w_s1;
    logic [LOGN-1:0] w_sh;
    logic [LOGN-1:0] w_u;
    logic [LOGN-1:0] w_b;
    logic [LOGN-2:0] w_tw;
    logic [AW-1:0]   w_head;
    logic            w_empty;
    logic            w_full;

    assign w_rd_en    = (r_state == ISSUE);
    assign w_start_ok = (r_state == IDLE) && start;
    // A valid with nothing outstanding is spurious: flag it, keep the FIFO.
    assign w_dec      = bf_valid && (r_cnt != '0);

    assign w_half = LOGN'(1) << r_s;
    assign w_mask = w_half - 1'b1;
    assign w_jx   = {1'b0, r_j};
    assign w_s1   = r_s + 1'b1;
    assign w_sh   = S_LAST - r_s;
    assign w_u    = ((w_jx >> r_s) << w_s1) | (w_jx & w_mask);
    assign w_b    = w_u + w_half;
    assign w_tw   = (r_j & w_mask[LOGN-2:0]) << w_sh;

    fft_addr_fifo #(
        .W     (AW),
        .DEPTH (BF_LAT + 2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rd_en),
        .i_din   ({w_u, w_b}),
        .i_pop   (w_dec),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);
    assign err           = r_err;
    assign mem_rd_en     = w_rd_en;
    assign mem_rd_addr_u = w_rd_en ? w_u : '0;
    assign mem_rd_addr_b = w_rd_en ? w_b : '0;
    assign tw_addr       = w_rd_en ? w_tw : '0;
    assign bf_en         = r_bf_en;
    assign mem_wr_en     = bf_valid;
    assign mem_wr_addr_u = w_dec ? w_head[AW-1:LOGN] : '0;
    assign mem_wr_addr_b = w_dec ? w_head[LOGN-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_bf_en <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + CW'(w_rd_en) - CW'(w_dec);
            r_bf_en <= w_rd_en;
            if (w_start_ok) begin
                r_err <= 1'b0;
            end
            if (bf_valid && (r_cnt == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_j     <= '0;
        end else begin
            unique case (1'b1)
                (r_state == IDLE): begin
                    if (start) begin
                        r_state <= ISSUE;
                        r_s     <= '0;
                        r_j     <= '0;
                    end
                end
                (r_state == ISSUE): begin
                    if (r_j == J_LAST) begin
                        r_state <= DRAIN;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                // Next stage only after every result of this one is written.
                (r_state == DRAIN): begin
                    if (r_cnt == '0) begin
                        if (r_s == S_LAST) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= ISSUE;
                            r_s     <= r_s + 1'b1;
                            r_j     <= '0;
                        end
                    end
                end
                (r_state == DONE): begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef FFT_STAGE_CTRL_CYCCNT_EN
    logic [31:0] r_cyc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc <= '0;
        end else if (w_start_ok) begin
            r_cyc <= '0;
        end else if (busy) begin
            r_cyc <= r_cyc + 1'b1;
        end
    end

    assign cycle_count = r_cyc;
`endif

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl at N=8, BF_LAT=3 with a 3-cycle
// butterfly delay model.
module tb_fft_stage_ctrl;

    localparam int N      = 8;
    localparam int LOGN   = 3;
    localparam int BF_LAT = 3;
    localparam int P      = N / 2 + BF_LAT + 2;
    localparam int NC     = 36;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            inj = 1'b0;
    logic            busy, done, err;
    logic            mem_rd_en, bf_en, bf_valid, mem_wr_en;
    logic [LOGN-1:0] mem_rd_addr_u, mem_rd_addr_b;
    logic [LOGN-1:0] mem_wr_addr_u, mem_wr_addr_b;
    logic [LOGN-2:0] tw_addr;
`ifdef FFT_STAGE_CTRL_CYCCNT_EN
    logic [31:0]     cycle_count;
`endif

    int total = 0;
    int bad = 0;

    int exp_u [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    logic            rd_q [NC];
    logic [LOGN-1:0] ru_q [NC];
    logic [LOGN-1:0] rb_q [NC];
    logic [LOGN-2:0] tw_q [NC];
    logic            wr_q [NC];
    logic [LOGN-1:0] wu_q [NC];
    logic [LOGN-1:0] wb_q [NC];
    logic            dn_q [NC];
    logic            bs_q [NC];
    logic            er_q [NC];

    logic [2:0] r_pipe;

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pipe <= '0;
        else        r_pipe <= {r_pipe[1:0], bf_en};
    end

    assign bf_valid = r_pipe[2] | inj;

    fft_stage_ctrl #(
        .N      (N),
        .LOGN   (LOGN),
        .BF_LAT (BF_LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr_u (mem_rd_addr_u),
        .mem_rd_addr_b (mem_rd_addr_b),
        .tw_addr       (tw_addr),
        .bf_en         (bf_en),
        .bf_valid      (bf_valid),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_addr_u (mem_wr_addr_u),
        .mem_wr_addr_b (mem_wr_addr_b)
`ifdef FFT_STAGE_CTRL_CYCCNT_EN
        ,
        .cycle_count   (cycle_count)
`endif
    );

    function automatic int issue_idx(input int c);
        int st, off;
        if (c < 1) return -1;
        st  = (c - 1) / P;
        off = (c - 1) % P;
        if (st >= LOGN || off >= N / 2) return -1;
        return st * (N / 2) + off;
    endfunction

    task automatic record(input int k);
        rd_q[k] = mem_rd_en;
        ru_q[k] = mem_rd_addr_u;
        rb_q[k] = mem_rd_addr_b;
        tw_q[k] = tw_addr;
        wr_q[k] = mem_wr_en;
        wu_q[k] = mem_wr_addr_u;
        wb_q[k] = mem_wr_addr_b;
        dn_q[k] = done;
        bs_q[k] = busy;
        er_q[k] = err;
    endtask

    // Cycle 0 is the cycle in which start is presented.
    task automatic run_fft(input bit hold);
        @(negedge clk);
        start = 1'b1;
        record(0);
        for (int k = 1; k < NC; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            record(k);
        end
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s: done=%b after %0d cycles, want 1", nm, done, n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] v;
        #1;
        v = {busy, done, err, mem_rd_en, mem_rd_addr_u, mem_rd_addr_b,
             tw_addr, bf_en, mem_wr_en, mem_wr_addr_u, mem_wr_addr_b};
        total++;
        if (v !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, mem_rd_en, done} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset: busy/rd/done=%b want 000",
                     {busy, mem_rd_en, done});
        end
    endtask

    task automatic test_stage_addresses;
        int ix;
        run_fft(1'b0);
        for (int c = 0; c < NC; c++) begin
            ix = issue_idx(c);
            total++;
            if (rd_q[c] !== (ix >= 0)) begin
                bad++;
                $display("FAIL rd_en c%0d: got %b want %b", c, rd_q[c], ix >= 0);
            end
            if (ix >= 0) begin
                total++;
                if (ru_q[c] !== LOGN'(exp_u[ix]) || rb_q[c] !== LOGN'(exp_b[ix])
                    || tw_q[c] !== (LOGN-1)'(exp_tw[ix])) begin
                    bad++;
                    $display("FAIL rd_addr c%0d: got u%0d b%0d tw%0d want u%0d b%0d tw%0d",
                             c, ru_q[c], rb_q[c], tw_q[c], exp_u[ix], exp_b[ix], exp_tw[ix]);
                end
            end
        end
    endtask

    task automatic test_writeback;
        int ix;
        run_fft(1'b0);
        for (int c = 0; c < NC; c++) begin
            ix = issue_idx(c - 1 - BF_LAT);
            total++;
            if (wr_q[c] !== (ix >= 0)) begin
                bad++;
                $display("FAIL wr_en c%0d: got %b want %b", c, wr_q[c], ix >= 0);
            end
            if (ix >= 0) begin
                total++;
                if (wu_q[c] !== LOGN'(exp_u[ix]) || wb_q[c] !== LOGN'(exp_b[ix])) begin
                    bad++;
                    $display("FAIL wr_addr c%0d: got u%0d b%0d want u%0d b%0d",
                             c, wu_q[c], wb_q[c], exp_u[ix], exp_b[ix]);
                end
            end
            if (wr_q[c] === 1'b1) begin
                total++;
                if (rd_q[c] !== 1'b0) begin
                    bad++;
                    $display("FAIL rd_wr_overlap c%0d: rd=%b want 0", c, rd_q[c]);
                end
            end
        end
    endtask

    task automatic test_completion;
        run_fft(1'b0);
        for (int c = 0; c < NC; c++) begin
            total++;
            if (dn_q[c] !== (c == 28)) begin
                bad++;
                $display("FAIL done c%0d: got %b want %b", c, dn_q[c], c == 28);
            end
            total++;
            if (bs_q[c] !== (c >= 1 && c <= 28)) begin
                bad++;
                $display("FAIL busy c%0d: got %b want %b", c, bs_q[c], c >= 1 && c <= 28);
            end
        end
`ifdef FFT_STAGE_CTRL_CYCCNT_EN
        total++;
        if (cycle_count !== 32'd28) begin
            bad++;
            $display("FAIL cycle_count: got %0d want 28", cycle_count);
        end
`endif
    endtask

    task automatic test_ignored_start;
        run_fft(1'b1);
        for (int c = 1; c < 30; c++) begin
            total++;
            if (rd_q[c] !== (issue_idx(c) >= 0)) begin
                bad++;
                $display("FAIL held_start_rd c%0d: got %b want %b",
                         c, rd_q[c], issue_idx(c) >= 0);
            end
        end
        total++;
        if (dn_q[28] !== 1'b1 || bs_q[29] !== 1'b0) begin
            bad++;
            $display("FAIL held_start_done: done28=%b busy29=%b want 1 0",
                     dn_q[28], bs_q[29]);
        end
        total++;
        if (rd_q[30] !== 1'b1 || ru_q[30] !== 3'd0 || rb_q[30] !== 3'd1) begin
            bad++;
            $display("FAIL restart_c30: rd=%b u%0d b%0d want 1 u0 b1",
                     rd_q[30], ru_q[30], rb_q[30]);
        end
        wait_done("held_start_second_run");
    endtask

    task automatic test_spurious_valid;
        @(negedge clk);
        inj = 1'b1;
        #1;
        total++;
        if (mem_wr_en !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL spurious_wr: wr_en=%b err=%b want 1 0", mem_wr_en, err);
        end
        @(negedge clk);
        inj = 1'b0;
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_set: got %b want 1", err);
        end
        repeat (2) @(negedge clk);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
        run_fft(1'b0);
        total++;
        if (er_q[0] !== 1'b1 || er_q[1] !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: c0=%b c1=%b want 1 0", er_q[0], er_q[1]);
        end
        total++;
        if (dn_q[28] !== 1'b1 || dn_q[27] !== 1'b0 || wr_q[5] !== 1'b1) begin
            bad++;
            $display("FAIL after_spurious_timing: done27=%b done28=%b wr5=%b want 0 1 1",
                     dn_q[27], dn_q[28], wr_q[5]);
        end
    endtask

    task automatic test_mid_reset;
        logic [31:0] v;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (mem_rd_en !== 1'b1 || mem_rd_addr_b !== 3'd3) begin
            bad++;
            $display("FAIL pre_reset_c11: rd=%b b%0d want 1 b3", mem_rd_en, mem_rd_addr_b);
        end
        #1;
        rst_n = 1'b0;
        #1;
        v = {busy, done, err, mem_rd_en, mem_rd_addr_u, mem_rd_addr_b,
             tw_addr, bf_en, mem_wr_en, mem_wr_addr_u, mem_wr_addr_b};
        total++;
        if (v !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %h want 0", v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_idle: busy=%b want 0", busy);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (mem_rd_en !== 1'b1 || mem_rd_addr_u !== 3'd0 || mem_rd_addr_b !== 3'd1
            || tw_addr !== 2'd0) begin
            bad++;
            $display("FAIL restart_after_reset: rd=%b u%0d b%0d tw%0d want 1 u0 b1 tw0",
                     mem_rd_en, mem_rd_addr_u, mem_rd_addr_b, tw_addr);
        end
        wait_done("mid_reset_rerun");
    endtask

    initial begin
        test_reset();
        test_stage_addresses();
        test_writeback();
        test_completion();
        test_ignored_start();
        test_spurious_valid();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
